// File: rtl/cfg_bitstream_tx.sv
// Configuration chain source: serialises parallel config words onto program_mode/jtag_data_in
// and packs the bits returning on jtag_data_out into readback words.
module cfg_bitstream_tx #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned TOTAL_BITS = 16384,
  parameter int unsigned CNT_W      = $clog2(TOTAL_BITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              program_mode,
  output logic              jtag_data_in,
  input  logic              jtag_data_out,
  output logic [WORD_W-1:0] rb_word,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  generate
    if (TOTAL_BITS == 0 || (TOTAL_BITS % WORD_W) != 0) begin : g_bad_cfg
      $error("cfg_bitstream_tx: TOTAL_BITS must be a nonzero multiple of WORD_W");
    end
  endgenerate

  logic [1:0]        state, state_nxt;
  logic              word_ready_nxt, pm_nxt, jdi_nxt, busy_nxt, done_nxt;
  logic [WORD_W-1:0] shreg, shreg_nxt;
  logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [WORD_W-1:0] rb_sh, rb_sh_nxt, rb_word_nxt;
  logic [IDX_W-1:0]  rb_idx, rb_idx_nxt;
  logic              rb_valid_nxt;
  logic              hs;

  assign hs = word_valid & word_ready;

  // bit_cnt is the index of the bit being (or about to be) presented on jtag_data_in
  always_comb begin
    state_nxt      = state;
    word_ready_nxt = 1'b0;
    pm_nxt         = 1'b0;
    jdi_nxt        = 1'b0;
    busy_nxt       = busy;
    done_nxt       = done;
    shreg_nxt      = shreg;
    bit_idx_nxt    = bit_idx;
    bit_cnt_nxt    = bit_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt      = S_LOAD;
          word_ready_nxt = 1'b1;
          busy_nxt       = 1'b1;
          done_nxt       = 1'b0;
          bit_idx_nxt    = '0;
          bit_cnt_nxt    = '0;
        end
      end
      S_LOAD: begin
        word_ready_nxt = 1'b1;
        if (hs) begin
          state_nxt      = S_SHIFT;
          shreg_nxt      = word_data;
          pm_nxt         = 1'b1;
          jdi_nxt        = word_data[0];
          bit_idx_nxt    = '0;
          word_ready_nxt = (LAST_IDX == IDX_W'(0)) && (bit_cnt < LAST_CNT);
        end
      end
      S_SHIFT: begin
        bit_cnt_nxt = bit_cnt + CNT_W'(1);
        if (bit_cnt == LAST_CNT) begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else if (bit_idx != LAST_IDX) begin
          pm_nxt         = 1'b1;
          bit_idx_nxt    = bit_idx + IDX_W'(1);
          jdi_nxt        = shreg[bit_idx_nxt];
          word_ready_nxt = (bit_idx_nxt == LAST_IDX) && (bit_cnt_nxt < LAST_CNT);
        end else if (hs) begin
          // next word follows with no bubble
          shreg_nxt      = word_data;
          pm_nxt         = 1'b1;
          jdi_nxt        = word_data[0];
          bit_idx_nxt    = '0;
          word_ready_nxt = (LAST_IDX == IDX_W'(0)) && (bit_cnt_nxt < LAST_CNT);
        end else begin
          state_nxt      = S_LOAD;
          word_ready_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Readback packer: samples the chain output on every shifting edge
  always_comb begin
    rb_sh_nxt    = rb_sh;
    rb_idx_nxt   = rb_idx;
    rb_word_nxt  = rb_word;
    rb_valid_nxt = 1'b0;
    if (state == S_IDLE && start) begin
      rb_idx_nxt = '0;
    end
    if (program_mode) begin
      rb_sh_nxt[rb_idx] = jtag_data_out;
      if (rb_idx == LAST_IDX) begin
        rb_idx_nxt   = '0;
        rb_word_nxt  = rb_sh_nxt;
        rb_valid_nxt = 1'b1;
      end else begin
        rb_idx_nxt = rb_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      word_ready   <= 1'b0;
      program_mode <= 1'b0;
      jtag_data_in <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      shreg        <= '0;
      bit_idx      <= '0;
      bit_cnt      <= '0;
      rb_sh        <= '0;
      rb_idx       <= '0;
      rb_word      <= '0;
      rb_valid     <= 1'b0;
    end else begin
      state        <= state_nxt;
      word_ready   <= word_ready_nxt;
      program_mode <= pm_nxt;
      jtag_data_in <= jdi_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      shreg        <= shreg_nxt;
      bit_idx      <= bit_idx_nxt;
      bit_cnt      <= bit_cnt_nxt;
      rb_sh        <= rb_sh_nxt;
      rb_idx       <= rb_idx_nxt;
      rb_word      <= rb_word_nxt;
      rb_valid     <= rb_valid_nxt;
    end
  end

endmodule

// File: tb/tb_cfg_bitstream_tx.sv
// Scoreboard bench for cfg_bitstream_tx with an 8-bit word, 32-bit chain configuration.
module tb_cfg_bitstream_tx;

  localparam int unsigned WORD_W     = 8;
  localparam int unsigned TOTAL_BITS = 32;
  localparam int NWORDS = TOTAL_BITS / WORD_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [WORD_W-1:0] word_data = '0;
  logic              word_valid = 1'b0;
  logic              word_ready;
  logic              program_mode;
  logic              jtag_data_in;
  logic              jtag_data_out;
  logic [WORD_W-1:0] rb_word;
  logic              rb_valid;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  cfg_bitstream_tx #(.WORD_W(WORD_W), .TOTAL_BITS(TOTAL_BITS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .program_mode(program_mode), .jtag_data_in(jtag_data_in), .jtag_data_out(jtag_data_out),
    .rb_word(rb_word), .rb_valid(rb_valid), .busy(busy), .done(done)
  );

  // Fabric chain model
  logic [31:0] chain = '0;
  logic [31:0] chain_init = '0;
  logic        chain_load = 1'b0;
  assign jtag_data_out = chain[0];
  always @(posedge clk) begin
    if (chain_load) chain <= chain_init;
    else if (program_mode) chain <= {jtag_data_in, chain[31:1]};
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0, pm_cnt = 0, nopm_cnt = 0, done_rise = 0, rb_cnt = 0, hs_cnt = 0, widx = 0;
  int stall_lo = 0, stall_hi = 0;
  bit drv_go = 1'b0;
  logic done_q = 1'b0;
  logic [WORD_W-1:0] words [NWORDS] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
  logic exp_bits [$];
  logic [WORD_W-1:0] exp_rb [$];

  // Word driver + output scoreboard, evaluated once per cycle on the falling edge
  task automatic scoreboard();
    logic eb;
    logic [WORD_W-1:0] ew;
    forever begin
      @(negedge clk);
      cyc++;
      if (program_mode) begin
        pm_cnt++;
        checks++;
        if (exp_bits.size() == 0) begin
          errors++;
          $display("FAIL bit_seq: jtag_data_in=%0b presented with no expected bit queued", jtag_data_in);
        end else begin
          eb = exp_bits.pop_front();
          if (jtag_data_in !== eb) begin
            errors++;
            $display("FAIL bit_seq: bit %0d jtag_data_in=%0b expected %0b", pm_cnt - 1, jtag_data_in, eb);
          end
        end
      end
      if (busy && !program_mode) nopm_cnt++;
      if (done && !done_q) done_rise++;
      done_q = done;
      if (rb_valid === 1'b1) begin
        rb_cnt++;
        checks++;
        if (exp_rb.size() == 0) begin
          errors++;
          $display("FAIL rb_word: pulse with rb_word=%0h but none expected", rb_word);
        end else begin
          ew = exp_rb.pop_front();
          if (rb_word !== ew) begin
            errors++;
            $display("FAIL rb_word: pulse %0d rb_word=%0h expected %0h", rb_cnt, rb_word, ew);
          end
        end
      end
      word_valid = 1'b0;
      word_data  = '0;
      if (drv_go && widx < NWORDS && !(cyc >= stall_lo && cyc < stall_hi)) begin
        word_valid = 1'b1;
        word_data  = words[widx];
      end
      if (word_valid && word_ready) begin
        for (int i = 0; i < int'(WORD_W); i++) exp_bits.push_back(word_data[i]);
        widx++;
        hs_cnt++;
      end
    end
  endtask

  task automatic prep(input logic [31:0] init);
    exp_bits.delete();
    exp_rb.delete();
    widx = 0; hs_cnt = 0; pm_cnt = 0; nopm_cnt = 0; done_rise = 0; rb_cnt = 0;
    stall_lo = 0; stall_hi = 0;
    for (int k = 0; k < NWORDS; k++) exp_rb.push_back(init[k*8 +: 8]);
    chain_init = init;
    chain_load = 1'b1;
    @(negedge clk); #1;
    chain_load = 1'b0;
    drv_go = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk); #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      if (!busy && done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; drv_go = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({word_ready, program_mode, jtag_data_in, rb_valid, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: {ready,pm,jdi,rbv,busy,done}=%b expected 000000",
               {word_ready, program_mode, jtag_data_in, rb_valid, busy, done});
    end
    checks++;
    if (rb_word !== '0) begin
      errors++;
      $display("FAIL reset_rb_word: rb_word=%0h expected 0", rb_word);
    end
    start = 1'b0; drv_go = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if ({word_ready, program_mode, jtag_data_in, rb_valid, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL idle_after_reset: {ready,pm,jdi,rbv,busy,done}=%b expected 000000",
               {word_ready, program_mode, jtag_data_in, rb_valid, busy, done});
    end
  endtask

  task automatic test_continuous();
    bit ok;
    prep(32'h1234_5678);
    pulse_start();
    wait_idle(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL cont_timeout: load did not complete, busy=%0b done=%0b", busy, done); end
    checks++;
    if (pm_cnt != 32) begin errors++; $display("FAIL cont_pm_cycles: %0d expected 32", pm_cnt); end
    checks++;
    if (nopm_cnt != 1) begin errors++; $display("FAIL cont_gaps: busy&!pm cycles=%0d expected 1", nopm_cnt); end
    checks++;
    if (hs_cnt != 4) begin errors++; $display("FAIL cont_handshakes: %0d expected 4", hs_cnt); end
    checks++;
    if (rb_cnt != 4) begin errors++; $display("FAIL cont_rb_pulses: %0d expected 4", rb_cnt); end
    checks++;
    if ({program_mode, jtag_data_in, word_ready, done_rise == 1} !== 4'b0001) begin
      errors++;
      $display("FAIL cont_end_state: pm=%0b jdi=%0b ready=%0b done_rises=%0d expected 0 0 0 1",
               program_mode, jtag_data_in, word_ready, done_rise);
    end
  endtask

  task automatic test_stall();
    bit ok;
    prep(32'h0F0F_A5A5);
    pulse_start();
    checks++;
    if (hs_cnt != 1) begin errors++; $display("FAIL stall_first_hs: handshakes=%0d expected 1", hs_cnt); end
    stall_lo = cyc + 7;
    stall_hi = cyc + 10;
    wait_idle(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_timeout: busy=%0b done=%0b", busy, done); end
    checks++;
    if (pm_cnt != 32) begin errors++; $display("FAIL stall_pm_cycles: %0d expected 32", pm_cnt); end
    checks++;
    if (nopm_cnt != 3) begin errors++; $display("FAIL stall_gaps: busy&!pm cycles=%0d expected 3", nopm_cnt); end
    checks++;
    if (exp_bits.size() != 0) begin errors++; $display("FAIL stall_leftover: %0d bits unsent expected 0", exp_bits.size()); end
  endtask

  task automatic test_mid_start();
    bit ok;
    prep(32'hCAFE_0001);
    pulse_start();
    for (int i = 0; i < 100 && pm_cnt < 10; i++) begin @(negedge clk); #1; end
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_start_busy: busy=%0b expected 1", busy); end
    wait_idle(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_start_timeout: busy=%0b done=%0b", busy, done); end
    checks++;
    if (pm_cnt != 32) begin errors++; $display("FAIL mid_start_pm_cycles: %0d expected 32", pm_cnt); end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (done_rise != 1 || hs_cnt != 4) begin
      errors++;
      $display("FAIL mid_start_once: done_rises=%0d handshakes=%0d expected 1 and 4", done_rise, hs_cnt);
    end
  endtask

  task automatic test_readback();
    bit ok;
    prep(32'hDEAD_BEEF);
    pulse_start();
    checks++;
    if ({done, busy} !== 2'b01) begin errors++; $display("FAIL back_to_back: done=%0b busy=%0b expected 0 1", done, busy); end
    wait_idle(200, ok);
    @(negedge clk); #1;
    checks++;
    if (!ok || rb_cnt != 4) begin errors++; $display("FAIL rb_pulses: completed=%0b pulses=%0d expected 1 and 4", ok, rb_cnt); end
    checks++;
    if (exp_rb.size() != 0) begin errors++; $display("FAIL rb_leftover: %0d words not seen expected 0", exp_rb.size()); end
  endtask

  task automatic test_abort();
    bit ok;
    prep(32'h5555_AAAA);
    pulse_start();
    for (int i = 0; i < 100 && pm_cnt < 13; i++) begin @(negedge clk); #1; end
    checks++;
    if (pm_cnt != 13 || program_mode !== 1'b1) begin
      errors++;
      $display("FAIL abort_reach: pm cycles=%0d pm=%0b expected 13 and 1", pm_cnt, program_mode);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({program_mode, jtag_data_in, word_ready, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL abort_outputs: {pm,jdi,ready,busy,done}=%b expected 00000",
               {program_mode, jtag_data_in, word_ready, busy, done});
    end
    @(negedge clk); #1;
    rst = 1'b1;
    prep(32'hDEAD_BEEF);
    pulse_start();
    for (int i = 0; i < 100 && pm_cnt < 20; i++) begin @(negedge clk); #1; end
    checks++;
    if ({done, busy} !== 2'b01) begin errors++; $display("FAIL reload_mid: done=%0b busy=%0b expected 0 1", done, busy); end
    wait_idle(200, ok);
    @(negedge clk); #1;
    checks++;
    if (!ok || pm_cnt != 32 || hs_cnt != 4 || rb_cnt != 4) begin
      errors++;
      $display("FAIL reload_full: done=%0b pm=%0d hs=%0d rb=%0d expected 1 32 4 4", ok, pm_cnt, hs_cnt, rb_cnt);
    end
  endtask

  initial begin
    fork
      scoreboard();
    join_none
    test_reset();
    test_continuous();
    test_stall();
    test_mid_start();
    test_readback();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cfg_bitstream_tx.md
Name: cfg_bitstream_tx

Overview:
Hardware source for the CGRA configuration chain. It accepts parallel configuration words over a valid/ready interface and serialises them onto the fabric's program_mode / jtag_data_in pins. It simultaneously packs the bits returned on jtag_data_out into readback words. It sits between the on-chip config memory/DMA and the cgra2_2 array, replacing bench-driven bit shifting.

Parameters:
WORD_W, 32, width of one configuration word; bits are shifted LSB first.
TOTAL_BITS, 16384, length of the configuration chain in bits; must be a nonzero multiple of WORD_W (elaboration error otherwise).
CNT_W, $clog2(TOTAL_BITS+1), width of the internal bit counter.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets)
start  in  1  one-cycle pulse; begins a full chain load when idle
word_data  in  WORD_W  next configuration word
word_valid  in  1  word_data valid
word_ready  out  1  block accepts word this cycle (handshake = valid & ready)
program_mode  out  1  1 = jtag_data_in carries a valid bit; the chain shifts on this cycle's rising edge
jtag_data_in  out  1  serial config bit to the fabric
jtag_data_out  in  1  serial bit leaving the fabric chain
rb_word  out  WORD_W  packed readback word, LSB = first bit received
rb_valid  out  1  one-cycle pulse, rb_word valid; no backpressure
busy  out  1  load in progress
done  out  1  sticky; set when TOTAL_BITS bits have been shifted, cleared by the next accepted start

Behaviour:
- Reset (async, rst=0): FSM=IDLE. word_ready, program_mode, jtag_data_in, rb_valid, busy and done are all 0. rb_word, counters and shift registers are 0. Reset mid-load aborts immediately with no further bits driven.
- FSM states: IDLE, LOAD, SHIFT.
- IDLE: start=1 -> LOAD, busy=1 and done=0 from the next cycle. start is ignored while busy.
- LOAD: word_ready=1, program_mode=0.
  - On handshake: capture word_data and go to SHIFT.
  - The next cycle drives program_mode=1, jtag_data_in=word_data[0].
- SHIFT: each cycle presents one bit (registered outputs), bit_idx 0..WORD_W-1, and increments bit_cnt.
  - word_ready=1 during the cycle presenting bit WORD_W-1, provided bit_cnt+1 < TOTAL_BITS.
  - Handshake in that cycle: the next word's bit 0 follows in the next cycle with no bubble, and program_mode stays 1.
  - No handshake: -> LOAD (stall). program_mode=0 during stall cycles; the chain holds.
  - After the bit with bit_cnt = TOTAL_BITS-1 has been presented: -> IDLE, busy=0, done=1, program_mode=0, and jtag_data_in returns to 0 on the next cycle.
- program_mode=1 in exactly TOTAL_BITS cycles per load; jtag_data_in is don't-care (driven 0) when program_mode=0.
- Readback: on every rising edge where program_mode=1, sample jtag_data_out into the rb shift register at position rb_idx, LSB first.
  - When rb_idx wraps from WORD_W-1 to 0, rb_word is updated and rb_valid pulses for 1 cycle, one cycle after that edge.
  - Exactly TOTAL_BITS/WORD_W rb pulses per load; rb_idx resets to 0 on start.
- Simultaneous start and rst=0: reset wins.
- word_valid while word_ready=0: ignored, and the data is not consumed.

Test Plan:
1. Reset: hold rst=0 with arbitrary inputs -> all outputs 0. Release rst, no start -> outputs stay 0, busy=0.
2. Continuous load (WORD_W=8, TOTAL_BITS=32), words 0xA5, 0x3C, 0xFF, 0x01 always valid:
   - start -> program_mode high for 32 consecutive cycles.
   - jtag_data_in sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1×8, 1,0×7.
   - 4 handshakes; then done=1, busy=0.
3. Stall: same config, word_valid dropped 3 cycles after the first word -> program_mode=0 for exactly those stall cycles, bit sequence unchanged, total program_mode-high cycles = 32.
4. Readback: model the chain as a 32-bit shift register preloaded with 0xDEADBEEF, then do a full load -> rb_word pulses 0xEF, 0xBE, 0xAD, 0xDE in order, 4 rb_valid pulses.
5. start pulsed mid-load -> ignored: bit count still 32, done asserted once.
6. rst=0 after 13 bits -> program_mode=0 immediately. A new start then loads the full 32 bits from word 0, with done clear until completion.
